// File: rtl/lifo_drain_streamer.sv
// Pops bytes from an 8-bit LIFO (counted or drain-until-empty) and streams them
// out over a valid/ready interface, closing each command with a done pulse.
module lifo_drain_streamer #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          cmd_valid,
    input  logic [CW-1:0] cmd_len,
    output logic          cmd_ready,
    output logic          lifo_ren,
    input  logic [DW-1:0] lifo_dout,
    input  logic          lifo_empty,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          done,
    output logic          short,
    output logic [CW-1:0] pop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_POP,
        S_WAIT,
        S_EMIT,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] pop_cnt_q, pop_cnt_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic          short_q, short_d;

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            pop_cnt_q <= '0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            pop_cnt_q <= pop_cnt_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            short_q   <= short_d;
        end
    end

    // Next-state and datapath updates; lifo_empty is only looked at in CHECK,
    // where the pop-to-check spacing guarantees a settled flag.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pop_cnt_d = pop_cnt_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        short_d   = short_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    len_d     = cmd_len;
                    pop_cnt_d = '0;
                    short_d   = 1'b0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((len_q != '0) && (pop_cnt_q == len_q)) begin
                    short_d = 1'b0;
                    state_d = S_FIN;
                end else if (lifo_empty) begin
                    short_d = (len_q != '0);
                    state_d = S_FIN;
                end else begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                m_data_d = lifo_dout;
                m_last_d = (len_q != '0) && ((pop_cnt_q + CW'(1)) == len_q);
                state_d  = S_EMIT;
            end
            S_EMIT: begin
                if (m_ready) begin
                    pop_cnt_d = pop_cnt_q + CW'(1);
                    state_d   = S_CHECK;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decode the state register only.
    assign cmd_ready = (state_q == S_IDLE);
    assign lifo_ren  = (state_q == S_POP);
    assign m_valid   = (state_q == S_EMIT);
    assign done      = (state_q == S_FIN);
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign short     = short_q;
    assign pop_cnt   = pop_cnt_q;

endmodule

// File: tb/tb_lifo_drain_streamer.sv
// Directed bench for lifo_drain_streamer with a small behavioural stack whose
// empty flag lags its pointer by one cycle.
module tb_lifo_drain_streamer;

    logic       clk = 1'b0;
    logic       rst_ = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_len = 8'd0;
    logic       cmd_ready;
    logic       lifo_ren;
    logic [7:0] lifo_dout;
    logic       lifo_empty;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic       done;
    logic       short;
    logic [7:0] pop_cnt;

    // Stack model
    logic [7:0] mem [0:255];
    int         sp = 0;
    logic [7:0] dout_r = 8'd0;
    logic       empty_r = 1'b1;
    logic       push_en = 1'b0;
    logic [7:0] push_data = 8'd0;

    // Monitor records
    logic [7:0] em_data [0:63];
    logic       em_last [0:63];
    int         em_wr = 0;
    int         ren_cnt = 0;
    int         bad_ren = 0;

    int tests = 0;
    int fails = 0;
    int em_base, ren_base, done_n, first_ren_n, bp_bad;

    assign lifo_dout  = dout_r;
    assign lifo_empty = empty_r;

    lifo_drain_streamer #(.DW(8), .CW(8)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .cmd_valid (cmd_valid),
        .cmd_len   (cmd_len),
        .cmd_ready (cmd_ready),
        .lifo_ren  (lifo_ren),
        .lifo_dout (lifo_dout),
        .lifo_empty(lifo_empty),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .done      (done),
        .short     (short),
        .pop_cnt   (pop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (push_en) begin
            mem[sp] <= push_data;
            sp      <= sp + 1;
        end else if (lifo_ren && sp != 0) begin
            dout_r <= mem[sp-1];
            sp     <= sp - 1;
        end
        empty_r <= (sp == 0);
    end

    always @(posedge clk) begin
        if (!rst_ && m_valid && m_ready) begin
            em_data[em_wr % 64] <= m_data;
            em_last[em_wr % 64] <= m_last;
            em_wr <= em_wr + 1;
        end
        if (lifo_ren) ren_cnt <= ren_cnt + 1;
        if (lifo_ren && sp == 0) bad_ren <= bad_ren + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        push_en   = 1'b1;
        push_data = b;
        @(negedge clk);
        push_en   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Leaves the caller at the first negedge after the accepting edge.
    task automatic issue_cmd(input logic [7:0] len);
        @(negedge clk);
        em_base   = em_wr;
        ren_base  = ren_cnt;
        cmd_valid = 1'b1;
        cmd_len   = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 1;
        first_ren_n = -1;
        while (n < 400) begin
            if (lifo_ren && first_ren_n < 0) first_ren_n = n;
            if (done) break;
            @(negedge clk);
            n++;
        end
        done_n = n;
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 32'(m_valid), 32'd1);
    endtask

    task automatic check_byte(input string tag, input int idx,
                              input logic [7:0] d, input logic l);
        check({tag, "_data"}, 32'(em_data[(em_base + idx) % 64]), 32'(d));
        check({tag, "_last"}, 32'(em_last[(em_base + idx) % 64]), 32'(l));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_lifo_ren", 32'(lifo_ren), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_short", 32'(short), 32'd0);
        check("rst_pop_cnt", 32'(pop_cnt), 32'd0);
        rst_ = 1'b0;
        repeat (2) @(negedge clk);

        // Counted pop of three bytes
        push(8'h11); push(8'h22); push(8'h33);
        issue_cmd(8'd3);
        wait_done();
        check("cnt_short", 32'(short), 32'd0);
        check("cnt_pop_cnt", 32'(pop_cnt), 32'd3);
        check("cnt_first_ren", 32'(first_ren_n), 32'd2);
        check("cnt_bytes", 32'(em_wr - em_base), 32'd3);
        check("cnt_ren", 32'(ren_cnt - ren_base), 32'd3);
        check_byte("cnt0", 0, 8'h33, 1'b0);
        check_byte("cnt1", 1, 8'h22, 1'b0);
        check_byte("cnt2", 2, 8'h11, 1'b1);
        @(negedge clk);
        check("cnt_hold_pop_cnt", 32'(pop_cnt), 32'd3);
        check("cnt_idle_ready", 32'(cmd_ready), 32'd1);

        // Drain mode, five bytes
        push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
        issue_cmd(8'd0);
        wait_done();
        check("drn_short", 32'(short), 32'd0);
        check("drn_pop_cnt", 32'(pop_cnt), 32'd5);
        check("drn_bytes", 32'(em_wr - em_base), 32'd5);
        check("drn_ren", 32'(ren_cnt - ren_base), 32'd5);
        check("drn_bad_ren", 32'(bad_ren), 32'd0);
        check_byte("drn0", 0, 8'h05, 1'b0);
        check_byte("drn1", 1, 8'h04, 1'b0);
        check_byte("drn2", 2, 8'h03, 1'b0);
        check_byte("drn3", 3, 8'h02, 1'b0);
        check_byte("drn4", 4, 8'h01, 1'b0);

        // Stack runs out before the requested length
        push(8'hC1); push(8'hC2);
        issue_cmd(8'd4);
        wait_done();
        check("sht_short", 32'(short), 32'd1);
        check("sht_pop_cnt", 32'(pop_cnt), 32'd2);
        check("sht_bytes", 32'(em_wr - em_base), 32'd2);
        check_byte("sht0", 0, 8'hC2, 1'b0);
        check_byte("sht1", 1, 8'hC1, 1'b0);

        // Empty stack at start
        repeat (3) @(negedge clk);
        issue_cmd(8'd7);
        wait_done();
        check("emp_latency", 32'(done_n), 32'd2);
        check("emp_short", 32'(short), 32'd1);
        check("emp_pop_cnt", 32'(pop_cnt), 32'd0);
        check("emp_bytes", 32'(em_wr - em_base), 32'd0);
        check("emp_ren", 32'(ren_cnt - ren_base), 32'd0);

        // Backpressure for ten cycles
        push(8'hA1); push(8'hB2);
        m_ready = 1'b0;
        issue_cmd(8'd2);
        wait_valid();
        bp_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid !== 1'b1 || m_data !== 8'hB2 || m_last !== 1'b0 || lifo_ren !== 1'b0)
                bp_bad++;
            @(negedge clk);
        end
        check("bp_stable", 32'(bp_bad), 32'd0);
        check("bp_ren_held", 32'(ren_cnt - ren_base), 32'd1);
        m_ready = 1'b1;
        wait_done();
        check("bp_short", 32'(short), 32'd0);
        check("bp_pop_cnt", 32'(pop_cnt), 32'd2);
        check_byte("bp0", 0, 8'hB2, 1'b0);
        check_byte("bp1", 1, 8'hA1, 1'b1);

        // Reset while a byte is held in EMIT
        push(8'h5A); push(8'h6B);
        m_ready = 1'b0;
        issue_cmd(8'd0);
        wait_valid();
        rst_ = 1'b1;
        @(negedge clk);
        check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mrst_lifo_ren", 32'(lifo_ren), 32'd0);
        check("mrst_m_valid", 32'(m_valid), 32'd0);
        check("mrst_m_data", 32'(m_data), 32'd0);
        check("mrst_m_last", 32'(m_last), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_short", 32'(short), 32'd0);
        check("mrst_pop_cnt", 32'(pop_cnt), 32'd0);
        rst_ = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        issue_cmd(8'd0);
        wait_done();
        check("post_short", 32'(short), 32'd0);
        check("post_pop_cnt", 32'(pop_cnt), 32'd1);
        check("post_bytes", 32'(em_wr - em_base), 32'd1);
        check_byte("post0", 0, 8'h5A, 1'b0);
        check("final_bad_ren", 32'(bad_ren), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
